// File: rtl/freelist_ckpt_pkg.sv
// freelist_pkg: shared sizing, types and the lane-counting helper for the checkpointed free list.
package freelist_pkg;

    localparam int FL_WIDTH    = 3;
    localparam int FL_NUM_PR   = 64;
    localparam int FL_NUM_ARCH = 32;
    localparam int FL_NUM_CKPT = 4;

    localparam int DEPTH = FL_NUM_PR - FL_NUM_ARCH;
    localparam int PRW   = $clog2(FL_NUM_PR);
    localparam int PTRW  = $clog2(DEPTH) + 1;
    localparam int CKW   = $clog2(FL_NUM_CKPT);

    typedef logic [PRW-1:0]  preg_t;
    typedef logic [PTRW-1:0] fl_ptr_t;
    typedef logic [CKW-1:0]  ckpt_tag_t;

    // Number of set bits in vec strictly below position idx.
    function automatic int popcount_below(input logic [31:0] vec, input int idx);
        int cnt;
        cnt = 0;
        for (int k = 0; k < 32; k++) begin
            if (k < idx && vec[k]) cnt++;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/freelist_ckpt_fl_lane_compact.sv
// fl_lane_compact: gives each enabled lane its slot offset (count of enabled lanes below it) and the total.
module fl_lane_compact
    import freelist_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0]         en_i,
    output logic [WIDTH-1:0][CW-1:0] offset_o,
    output logic [CW-1:0]            total_o
);

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            offset_o[i] = CW'(popcount_below(32'(en_i), i));
        end
        total_o = CW'(popcount_below(32'(en_i), WIDTH));
    end

endmodule

// File: rtl/freelist_ckpt.sv
// freelist_ckpt: R10K physical-register free list with per-branch head checkpoints.
// Define FREELIST_DUPCHK_EN to add the in-list bitmap, duplicate-free filtering and dup_err.
module freelist_ckpt
    import freelist_pkg::*;
#(
    parameter int WIDTH    = FL_WIDTH,
    parameter int NUM_PR   = FL_NUM_PR,
    parameter int NUM_ARCH = FL_NUM_ARCH,
    parameter int NUM_CKPT = FL_NUM_CKPT,
    localparam int DEP  = NUM_PR - NUM_ARCH,
    localparam int IDXW = $clog2(DEP),
    localparam int PTW  = IDXW + 1,
    localparam int PW   = $clog2(NUM_PR),
    localparam int TW   = $clog2(NUM_CKPT),
    localparam int CNTW = $clog2(DEP + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         disp_req,
    output logic [WIDTH-1:0]         disp_grant,
    output logic [WIDTH-1:0][PW-1:0] disp_preg,
    input  logic [WIDTH-1:0]         ret_en,
    input  logic [WIDTH-1:0][PW-1:0] ret_preg,
    input  logic                     ckpt_take,
    input  logic [TW-1:0]            ckpt_tag,
    input  logic                     recover_en,
    input  logic [TW-1:0]            recover_tag,
    output logic [CNTW-1:0]          avail_cnt,
    output logic [PTW-1:0]           head_ptr,
`ifdef FREELIST_DUPCHK_EN
    output logic                     dup_err,
`endif
    output logic                     overflow_err
);

    localparam int LCW = $clog2(WIDTH + 1);

    if ((1 << IDXW) != DEP) begin : g_depth_chk
        $error("freelist_ckpt: NUM_PR - NUM_ARCH must be a power of two");
    end

    logic [PTW-1:0]  head_q, head_d, tail_q, tail_d, headNext, avail;
    logic [PW-1:0]   arr_q [DEP];
    logic [PW-1:0]   arr_d [DEP];
    logic [PTW-1:0]  ckpt_q [NUM_CKPT];
    logic            ovf_q, ovfNow;
    logic [WIDTH-1:0] grant, retEff, retKeep;
    logic [WIDTH-1:0][LCW-1:0] grantOff, retOff;
    logic [LCW-1:0]  grantCnt, retCnt;
    logic [IDXW-1:0] allocIdx [WIDTH];
    logic [IDXW-1:0] retIdx [WIDTH];

    assign avail        = tail_q - head_q;
    assign avail_cnt    = CNTW'(avail);
    assign head_ptr     = head_q;
    assign overflow_err = ovf_q;
    assign disp_grant   = grant;

    // A lane is granted when the requests below it still leave a free entry for it.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            grant[i] = disp_req[i] && !recover_en && !reset &&
                       (popcount_below(32'(disp_req), i) < int'(avail));
        end
    end

    fl_lane_compact #(.WIDTH(WIDTH), .CW(LCW)) u_grant_cmp (
        .en_i     (grant),
        .offset_o (grantOff),
        .total_o  (grantCnt)
    );

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            allocIdx[i]  = head_q[IDXW-1:0] + IDXW'(grantOff[i]);
            disp_preg[i] = grant[i] ? arr_q[allocIdx[i]] : '0;
        end
    end

`ifdef FREELIST_DUPCHK_EN
    logic [NUM_PR-1:0] inlist_q, inlist_d;
    logic              dup_q;
    logic [WIDTH-1:0]  dupLane;
    logic [PTW-1:0]    regionLen;

    // Later lanes repeating an older lane's PR are the ones dropped.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            dupLane[i] = ret_en[i] && inlist_q[ret_preg[i]];
            for (int j = 0; j < i; j++) begin
                if (ret_en[i] && ret_en[j] && ret_preg[j] == ret_preg[i]) dupLane[i] = 1'b1;
            end
        end
    end
    assign retEff    = ret_en & ~dupLane;
    assign regionLen = tail_d - head_d;
    assign dup_err   = dup_q;
`else
    assign retEff = ret_en;
`endif

    fl_lane_compact #(.WIDTH(WIDTH), .CW(LCW)) u_ret_cmp (
        .en_i     (retEff),
        .offset_o (retOff),
        .total_o  (retCnt)
    );

    assign ovfNow   = (int'(avail) - int'(grantCnt) + int'(retCnt)) > DEP;
    assign retKeep  = ovfNow ? '0 : retEff;
    assign headNext = head_q + PTW'(grantCnt);
    assign head_d   = recover_en ? ckpt_q[recover_tag] : headNext;
    assign tail_d   = ovfNow ? tail_q : tail_q + PTW'(retCnt);

    always_comb begin
        arr_d = arr_q;
        for (int i = 0; i < WIDTH; i++) begin
            retIdx[i] = tail_q[IDXW-1:0] + IDXW'(retOff[i]);
            if (retKeep[i]) arr_d[retIdx[i]] = ret_preg[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= PTW'(DEP);
            ovf_q  <= 1'b0;
            for (int i = 0; i < DEP; i++) arr_q[i] <= PW'(NUM_ARCH + i);
            for (int c = 0; c < NUM_CKPT; c++) ckpt_q[c] <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            arr_q  <= arr_d;
            if (ovfNow) ovf_q <= 1'b1;
            if (ckpt_take && !recover_en) ckpt_q[ckpt_tag] <= headNext;
        end
    end

`ifdef FREELIST_DUPCHK_EN
    // On recovery the bitmap is rebuilt from the live region of the array as it stands next cycle.
    always_comb begin
        inlist_d = inlist_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (grant[i]) inlist_d[disp_preg[i]] = 1'b0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (retKeep[i]) inlist_d[ret_preg[i]] = 1'b1;
        end
        if (recover_en) begin
            inlist_d = '0;
            for (int k = 0; k < DEP; k++) begin
                if (k < int'(regionLen)) inlist_d[arr_d[head_d[IDXW-1:0] + IDXW'(k)]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            inlist_q <= {{DEP{1'b1}}, {NUM_ARCH{1'b0}}};
            dup_q    <= 1'b0;
        end else begin
            inlist_q <= inlist_d;
            if (|dupLane) dup_q <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_freelist_ckpt.sv
// tb_freelist_ckpt: scoreboard bench for freelist_ckpt against a ring-of-entries reference model.
module tb_freelist_ckpt;
    import freelist_pkg::*;

    localparam int W     = FL_WIDTH;
    localparam int D     = DEPTH;
    localparam int NPR   = FL_NUM_PR;
    localparam int NARCH = FL_NUM_ARCH;
    localparam int NCK   = FL_NUM_CKPT;
    localparam int PMOD  = 2 * D;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [W-1:0] disp_req = '0, disp_grant, ret_en = '0;
    logic [W-1:0][PRW-1:0] disp_preg;
    logic [W-1:0][PRW-1:0] ret_preg = '0;
    logic ckpt_take = 1'b0, recover_en = 1'b0;
    ckpt_tag_t ckpt_tag = '0, recover_tag = '0;
    logic [$clog2(D+1)-1:0] avail_cnt;
    fl_ptr_t head_ptr;
    logic overflow_err;
`ifdef FREELIST_DUPCHK_EN
    logic dup_err;
`endif

    always #5 clock = ~clock;

    freelist_ckpt dut (
        .clock        (clock),
        .reset        (reset),
        .disp_req     (disp_req),
        .disp_grant   (disp_grant),
        .disp_preg    (disp_preg),
        .ret_en       (ret_en),
        .ret_preg     (ret_preg),
        .ckpt_take    (ckpt_take),
        .ckpt_tag     (ckpt_tag),
        .recover_en   (recover_en),
        .recover_tag  (recover_tag),
        .avail_cnt    (avail_cnt),
        .head_ptr     (head_ptr),
`ifdef FREELIST_DUPCHK_EN
        .dup_err      (dup_err),
`endif
        .overflow_err (overflow_err)
    );

    typedef struct packed {
        logic                  stateValid;
        logic [W-1:0]          grant;
        logic [W-1:0][PRW-1:0] preg;
        logic [7:0]            avail;
        logic [7:0]            head;
        logic                  ovf;
        logic                  dup;
    } exp_t;

    exp_t expQ[$];
    exp_t mon;
    int checks = 0;
    int passes = 0;

    // Reference model: free entries live in mem[] between free-running head/tail counts.
    int mHead, mTail;
    int mem [D];
    int mCk [NCK];
    bit mOvf, mDup;
    bit inList [NPR];
    logic [W-1:0][PRW-1:0] mLastGrant;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    function automatic logic [W-1:0][PRW-1:0] rpv(input int a, input int b, input int c);
        logic [W-1:0][PRW-1:0] r;
        r = '0;
        r[0] = PRW'(a);
        r[1] = PRW'(b);
        r[2] = PRW'(c);
        return r;
    endfunction

    function automatic void modelReset();
        mHead = 0;
        mTail = D;
        mOvf  = 1'b0;
        mDup  = 1'b0;
        mLastGrant = '0;
        for (int i = 0; i < D; i++) mem[i] = NARCH + i;
        for (int c = 0; c < NCK; c++) mCk[c] = 0;
        for (int p = 0; p < NPR; p++) inList[p] = (p >= NARCH);
    endfunction

    task automatic doReset();
        exp_t e;
        @(posedge clock); #1;
        reset       = 1'b1;
        disp_req    = W'($urandom);
        ret_en      = W'($urandom);
        for (int i = 0; i < W; i++) ret_preg[i] = PRW'($urandom);
        ckpt_take   = 1'($urandom);
        ckpt_tag    = ckpt_tag_t'($urandom);
        recover_en  = 1'($urandom);
        recover_tag = ckpt_tag_t'($urandom);
        e = '0;
        expQ.push_back(e);
        modelReset();
    endtask

    task automatic applyStimulus(input logic [W-1:0] req, input logic [W-1:0] ren,
                                 input logic [W-1:0][PRW-1:0] rp, input logic take,
                                 input int ctag, input logic rec, input int rtag);
        exp_t e;
        int avail, below, g, f, k, len;
        logic [W-1:0] keep;
        @(posedge clock); #1;
        reset       = 1'b0;
        disp_req    = req;
        ret_en      = ren;
        ret_preg    = rp;
        ckpt_take   = take;
        ckpt_tag    = ckpt_tag_t'(ctag);
        recover_en  = rec;
        recover_tag = ckpt_tag_t'(rtag);

        avail = ((mTail - mHead) % PMOD + PMOD) % PMOD;
        e = '0;
        e.stateValid = 1'b1;
        e.avail = 8'(avail);
        e.head  = 8'(mHead);
        e.ovf   = mOvf;
        e.dup   = mDup;
        below = 0;
        g = 0;
        for (int i = 0; i < W; i++) begin
            if (req[i] && below < avail && !rec) begin
                e.grant[i] = 1'b1;
                e.preg[i]  = PRW'(mem[(mHead + g) % D]);
                g++;
            end
            if (req[i]) below++;
        end
        mLastGrant = e.preg;

        keep = ren;
`ifdef FREELIST_DUPCHK_EN
        for (int i = 0; i < W; i++) begin
            if (ren[i]) begin
                if (inList[rp[i]]) keep[i] = 1'b0;
                for (int j = 0; j < i; j++) if (ren[j] && rp[j] == rp[i]) keep[i] = 1'b0;
            end
        end
        if (keep != ren) mDup = 1'b1;
`endif
        for (int i = 0; i < W; i++) if (e.grant[i]) inList[e.preg[i]] = 1'b0;

        f = $countones(keep);
        if (avail - g + f > D) begin
            mOvf = 1'b1;
            keep = '0;
            f = 0;
        end
        k = 0;
        for (int i = 0; i < W; i++) begin
            if (keep[i]) begin
                mem[(mTail + k) % D] = int'(rp[i]);
                inList[rp[i]] = 1'b1;
                k++;
            end
        end
        mTail = (mTail + f) % PMOD;

        if (take && !rec) mCk[ctag] = (mHead + g) % PMOD;
        if (rec) begin
            mHead = mCk[rtag];
            for (int p = 0; p < NPR; p++) inList[p] = 1'b0;
            len = ((mTail - mHead) % PMOD + PMOD) % PMOD;
            for (int q = 0; q < len && q < D; q++) inList[mem[(mHead + q) % D]] = 1'b1;
        end else begin
            mHead = (mHead + g) % PMOD;
        end
        expQ.push_back(e);
    endtask

    task automatic idle();
        applyStimulus('0, '0, '0, 1'b0, 0, 1'b0, 0);
    endtask

    // Monitor: pops one expectation per presented cycle and compares away from the clock edge.
    always @(negedge clock) begin
        if (expQ.size() > 0) begin
            mon = expQ.pop_front();
            checkOutput("disp_grant", int'(disp_grant), int'(mon.grant));
            for (int i = 0; i < W; i++)
                checkOutput($sformatf("disp_preg[%0d]", i), int'(disp_preg[i]), int'(mon.preg[i]));
            if (mon.stateValid) begin
                checkOutput("avail_cnt", int'(avail_cnt), int'(mon.avail));
                checkOutput("head_ptr", int'(head_ptr), int'(mon.head));
                checkOutput("overflow_err", int'(overflow_err), int'(mon.ovf));
`ifdef FREELIST_DUPCHK_EN
                checkOutput("dup_err", int'(dup_err), int'(mon.dup));
`endif
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W-1:0][PRW-1:0] rr;

        // Full-width grant straight out of reset.
        doReset();
        applyStimulus(3'b111, '0, '0, 1'b0, 0, 1'b0, 0);
        @(negedge clock);
        checkOutput("reset_grant", int'(disp_grant), 7);
        checkOutput("reset_preg0", int'(disp_preg[0]), 32);
        checkOutput("reset_preg1", int'(disp_preg[1]), 33);
        checkOutput("reset_preg2", int'(disp_preg[2]), 34);
        idle();
        @(negedge clock);
        checkOutput("after3_avail", int'(avail_cnt), 29);
        checkOutput("after3_head", int'(head_ptr), 3);

        // Drain to two entries, then partial grant, then empty.
        repeat (9) applyStimulus(3'b111, '0, '0, 1'b0, 0, 1'b0, 0);
        applyStimulus(3'b111, '0, '0, 1'b0, 0, 1'b0, 0);
        @(negedge clock);
        checkOutput("drain_grant", int'(disp_grant), 3);
        idle();
        @(negedge clock);
        checkOutput("empty_avail", int'(avail_cnt), 0);
        applyStimulus(3'b111, '0, '0, 1'b0, 0, 1'b0, 0);
        @(negedge clock);
        checkOutput("empty_grant", int'(disp_grant), 0);

        // Non-contiguous request.
        doReset();
        applyStimulus(3'b101, '0, '0, 1'b0, 0, 1'b0, 0);
        @(negedge clock);
        checkOutput("gap_grant", int'(disp_grant), 5);
        checkOutput("gap_preg0", int'(disp_preg[0]), 32);
        checkOutput("gap_preg1", int'(disp_preg[1]), 0);
        checkOutput("gap_preg2", int'(disp_preg[2]), 33);
        idle();
        @(negedge clock);
        checkOutput("gap_head", int'(head_ptr), 2);

        // Checkpoint at head 5 with two grants, then recover while retiring one.
        doReset();
        applyStimulus(3'b111, '0, '0, 1'b0, 0, 1'b0, 0);
        applyStimulus(3'b011, '0, '0, 1'b0, 0, 1'b0, 0);
        applyStimulus(3'b011, '0, '0, 1'b1, 1, 1'b0, 0);
        applyStimulus(3'b111, '0, '0, 1'b0, 0, 1'b0, 0);
        applyStimulus(3'b111, '0, '0, 1'b0, 0, 1'b0, 0);
        applyStimulus(3'b111, 3'b001, rpv(5, 0, 0), 1'b0, 0, 1'b1, 1);
        @(negedge clock);
        checkOutput("recover_grant", int'(disp_grant), 0);
        idle();
        @(negedge clock);
        checkOutput("recover_head", int'(head_ptr), 7);
        checkOutput("recover_avail", int'(avail_cnt), 26);

        // Overflow: three frees with only one entry in use.
        doReset();
        applyStimulus(3'b001, '0, '0, 1'b0, 0, 1'b0, 0);
        applyStimulus('0, 3'b111, rpv(1, 2, 3), 1'b0, 0, 1'b0, 0);
        idle();
        @(negedge clock);
        checkOutput("ovf_flag", int'(overflow_err), 1);
        checkOutput("ovf_avail", int'(avail_cnt), 31);

        // Wrap: frees 10,11,12 land at entries 31,0,1 and come back out in that order.
        doReset();
        rr = rpv(0, 1, 2);
        for (int c = 0; c < 10; c++) begin
            applyStimulus(3'b111, 3'b111, rr, 1'b0, 0, 1'b0, 0);
            rr = mLastGrant;
        end
        applyStimulus(3'b111, 3'b001, rpv(3, 0, 0), 1'b0, 0, 1'b0, 0);
        applyStimulus(3'b111, 3'b111, rpv(10, 11, 12), 1'b0, 0, 1'b0, 0);
        repeat (9) applyStimulus(3'b111, '0, '0, 1'b0, 0, 1'b0, 0);
        applyStimulus(3'b111, '0, '0, 1'b0, 0, 1'b0, 0);
        @(negedge clock);
        checkOutput("wrap_preg0", int'(disp_preg[0]), 10);
        checkOutput("wrap_preg1", int'(disp_preg[1]), 11);
        checkOutput("wrap_preg2", int'(disp_preg[2]), 12);

`ifdef FREELIST_DUPCHK_EN
        doReset();
        applyStimulus(3'b111, 3'b001, rpv(40, 0, 0), 1'b0, 0, 1'b0, 0);
        idle();
        @(negedge clock);
        checkOutput("dup_inlist", int'(dup_err), 1);
        doReset();
        applyStimulus(3'b111, 3'b011, rpv(5, 5, 0), 1'b0, 0, 1'b0, 0);
        idle();
        @(negedge clock);
        checkOutput("dup_samecycle", int'(dup_err), 1);
        checkOutput("dup_samecycle_avail", int'(avail_cnt), 30);
`endif

        // Randomized traffic against the model.
        doReset();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                doReset();
            end else begin
                for (int i = 0; i < W; i++) rr[i] = PRW'($urandom_range(0, NPR - 1));
                applyStimulus(W'($urandom), W'($urandom) & W'($urandom), rr,
                              1'($urandom_range(0, 3) == 0), int'($urandom_range(0, NCK - 1)),
                              1'($urandom_range(0, 11) == 0), int'($urandom_range(0, NCK - 1)));
            end
        end

        repeat (3) @(negedge clock);
        #1;
        if (expQ.size() != 0) checkOutput("queue_drain", expQ.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/freelist_ckpt.md
Name: freelist_ckpt

Overview:
- Parametrised N-wide physical-register free list for the R10K rename stage: allocates up to WIDTH free PRs per cycle to dispatch and accepts up to WIDTH freed PRs per cycle from retire.
- Adds per-branch head checkpoints, so branch recovery restores the head pointer directly. There is no full-flush-to-tail recovery.
- Sits between rename/dispatch, the ROB retire path and the branch unit.

Parameters:
- WIDTH, 3, dispatch/retire lanes per cycle.
- NUM_PR, 64, total physical registers; PR index width PRW = $clog2(NUM_PR).
- NUM_ARCH, 32, architectural registers; DEPTH = NUM_PR-NUM_ARCH entries in the list.
- NUM_CKPT, 4, branch checkpoints; tag width CKW = $clog2(NUM_CKPT).

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high
- disp_req  in  WIDTH  per-lane allocation request; lane 0 oldest
- disp_grant  out  WIDTH  per-lane allocation granted (combinational)
- disp_preg  out  WIDTH x PRW  allocated PR per lane; 0 where not granted
- ret_en  in  WIDTH  per-lane free request; lane 0 oldest
- ret_preg  in  WIDTH x PRW  PR being freed
- ckpt_take  in  1  snapshot head after this cycle's grants
- ckpt_tag  in  CKW  checkpoint slot to write
- recover_en  in  1  branch mispredict: restore checkpoint
- recover_tag  in  CKW  slot to restore
- avail_cnt  out  $clog2(DEPTH+1)  free entries, registered state
- head_ptr  out  $clog2(DEPTH)+1  head pointer including wrap bit
- overflow_err  out  1  sticky: retire exceeded capacity

Behaviour:
- Pointers are $clog2(DEPTH)+1 bits wide (wrap bit). avail_cnt = tail - head, modulo 2^(ptr width). No full flag.
- Reset: head=0, tail=DEPTH (wrap bit set), avail_cnt=DEPTH, array[i]=NUM_ARCH+i, all checkpoints=0, overflow_err=0. disp_grant=0 in the cycle reset is asserted.
- Grant: lane i is granted iff disp_req[i] && popcount(disp_req[i-1:0]) < avail_cnt && !recover_en. Requests are not required to be contiguous.
- Allocation: granted lane i gets array[head + popcount(granted lanes below i)], index mod DEPTH. Ungranted lanes output 0. Combinational, zero latency.
- Next head: head_n = head + popcount(disp_grant). Next tail: tail_n = tail + popcount(ret_en).
- Retire writes ret_preg of the k-th enabled lane (oldest first) into array[tail+k]. Freed entries become allocatable the next cycle; no same-cycle bypass.
- Overflow: if avail_cnt - grants + frees > DEPTH, set overflow_err and drop the whole retire group (tail unchanged). overflow_err clears only on reset.
- Checkpoint: when ckpt_take && !recover_en, ckpt[ckpt_tag] <= head_n, including this cycle's grants. Overwriting a live slot is legal.
- Recovery: when recover_en, head <= ckpt[recover_tag]. All grants are forced to 0, ckpt_take is ignored, and retire still proceeds (tail <= tail_n).
- Recovery when recover_tag equals a slot written in the same cycle: ignored write, old value used.
- Wrap-around: every index reduces mod DEPTH. DEPTH must be a power of two; an elaboration-time check fails otherwise.
- Reset mid-operation overrides all inputs and restores the reset state above.

Optional Feature:
- FREELIST_DUPCHK_EN
- Defined: adds an NUM_PR-bit in-list bitmap.
  - Reset value: bits NUM_ARCH..NUM_PR-1 set.
  - Set on retire; cleared on grant.
  - Recovery rebuilds it from the array region [restored head, tail_n).
  - Retiring a PR whose bit is already set, or two lanes freeing the same PR in one cycle, raises output dup_err (sticky) and drops that lane only.
- Undefined: no bitmap, no dup_err port, and no extra logic.

Decomposition:
- freelist_pkg holds:
  - localparams DEPTH, PRW, PTRW, CKW;
  - typedefs preg_t, fl_ptr_t, ckpt_tag_t;
  - function popcount_below(vec, idx).
- One sub-module, fl_lane_compact: given an enable vector, it produces per-lane offsets and a total count. It is instantiated twice, once for dispatch grants and once for retire.

Test Plan:
- Reset, then disp_req=3'b111 -> grants 111, disp_preg={lane0:32, lane1:33, lane2:34}; next cycle avail_cnt=29, head_ptr=3.
- Drain to avail_cnt=2, then disp_req=3'b111 -> disp_grant=3'b011 with PRs of the next two entries; next cycle avail_cnt=0 and disp_grant=000 for any request.
- disp_req=3'b101 at head=0 -> lane0=32, lane2=33, lane1 output 0; head +2.
- Take ckpt tag 1 on a cycle granting 2 from head=5 (ckpt=7). Dispatch 6 more, retire 1 in the recover cycle, recover tag 1 -> head_ptr=7, tail +1, grants 0 that cycle.
- Wrap: cycle head/tail past 31 with retire ret_preg=10,11,12 written at tail=31 -> entries 31,0,1 hold 10,11,12, allocated in that order later.
- Retire 3 when avail_cnt=31 -> overflow_err=1, tail unchanged. With FREELIST_DUPCHK_EN, retiring PR 40 while PR 40 is still in the list -> dup_err=1.
